// File: rtl/exc_mem_wb_reg_pkg.sv
// Shared definitions for the MEM->WB commit stage: exception codes, CP0
// register addresses, and the small enums used by the collector.
package exc_mem_wb_reg_pkg;

    // CP0 Cause.ExcCode values
    localparam logic [4:0] EXC_INT  = 5'h00;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_SYS  = 5'h08;
    localparam logic [4:0] EXC_BP   = 5'h09;
    localparam logic [4:0] EXC_RI   = 5'h0a;
    localparam logic [4:0] EXC_OV   = 5'h0c;

    // CP0 register addresses, packed as {rd[4:0], sel[0]} into six bits
    localparam logic [5:0] cp0addr_badvaddr = {5'd8,  1'b0};
    localparam logic [5:0] cp0addr_count    = {5'd9,  1'b0};
    localparam logic [5:0] cp0addr_compare  = {5'd11, 1'b0};
    localparam logic [5:0] cp0addr_status   = {5'd12, 1'b0};
    localparam logic [5:0] cp0addr_cause    = {5'd13, 1'b0};
    localparam logic [5:0] cp0addr_epc      = {5'd14, 1'b0};

    // Exception entry point that CP0 redirects fetch to on ClrStpJmp
    localparam logic [31:0] EXC_VECTOR = 32'hbfc00380;

    // Which address becomes the BadVAddr candidate
    typedef enum logic [1:0] {
        BADV_NONE = 2'd0,
        BADV_PC   = 2'd1,
        BADV_LS   = 2'd2
    } badv_sel_t;

    // WB slot occupancy
    typedef enum logic [1:0] {
        SLOT_EMPTY  = 2'd0,
        SLOT_NORMAL = 2'd1,
        SLOT_EXC    = 2'd2
    } slot_state_t;

    function automatic logic [31:0] badv_mux(input badv_sel_t sel,
                                             input logic [31:0] pc,
                                             input logic [31:0] ls_addr);
        logic [31:0] v;
        v = 32'h0;
        case (sel)
            BADV_PC: v = pc;
            BADV_LS: v = ls_addr;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/exc_prio_enc.sv
// Seven-source exception priority encoder: picks the winning fault, its
// ExcCode, and which address (if any) is reported as BadVAddr.
module exc_prio_enc
    import exc_mem_wb_reg_pkg::*;
(
    input  logic       if_adel,
    input  logic       ri,
    input  logic       ov,
    input  logic       sys,
    input  logic       bp,
    input  logic       ld_adel,
    input  logic       st_ades,
    output logic       exc,
    output logic [4:0] exc_code,
    output badv_sel_t  badv_sel
);

    // Fixed priority chain, highest first
    always_comb begin
        exc      = 1'b1;
        exc_code = EXC_INT;
        badv_sel = BADV_NONE;
        if (if_adel) begin
            exc_code = EXC_ADEL;
            badv_sel = BADV_PC;
        end else if (ri) begin
            exc_code = EXC_RI;
        end else if (ov) begin
            exc_code = EXC_OV;
        end else if (sys) begin
            exc_code = EXC_SYS;
        end else if (bp) begin
            exc_code = EXC_BP;
        end else if (ld_adel) begin
            exc_code = EXC_ADEL;
            badv_sel = BADV_LS;
        end else if (st_ades) begin
            exc_code = EXC_ADES;
            badv_sel = BADV_LS;
        end else begin
            exc = 1'b0;
        end
    end

endmodule

// File: rtl/exc_mem_wb_reg.sv
// MEM->WB pipeline register and exception collector; producing end of the
// CP0 commit interface. CP0's ClrStpJmp drops the committing slot.
//
//   state       | meaning
//   ------------+---------------------------------------------------------
//   SLOT_EMPTY  | WB holds a bubble (reset, flush, or nothing loaded)
//   SLOT_NORMAL | WB holds an instruction with no exception and no eret
//   SLOT_EXC    | WB holds an exception or eret; CP0 flushes next edge
module exc_mem_wb_reg
    import exc_mem_wb_reg_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_to_wb_valid,
    output logic        wb_allowin,
    input  logic [31:0] mem_pc,
    input  logic        mem_bd,
    input  logic        mem_exc_if_adel,
    input  logic        mem_exc_ri,
    input  logic        mem_exc_ov,
    input  logic        mem_exc_sys,
    input  logic        mem_exc_bp,
    input  logic        mem_exc_ld_adel,
    input  logic        mem_exc_st_ades,
    input  logic [31:0] mem_ls_addr,
    input  logic        mem_eret,
    input  logic        mem_mtc0,
    input  logic        mem_mfc0,
    input  logic [5:0]  mem_cp0_addr,
    input  logic [31:0] mem_rt_data,
    input  logic        ClrStpJmp,
    output logic        valid_r,
    output logic        mem_to_wb_exception_r,
    output logic [4:0]  mem_to_wb_ExcCode_r,
    output logic        mem_to_wb_bd_r,
    output logic [31:0] mem_to_wb_PC_r,
    output logic [31:0] error_VAddr,
    output logic        mem_to_wb_eret_r,
    output logic        mem_to_wb_mtc0_op_r,
    output logic        mem_to_wb_mfc0_op_r,
    output logic [5:0]  cp0_addr,
    output logic [31:0] mtc0_data,
    output logic        pipe_flush,
    output logic        exc_in_flight
);

    logic        wb_ready_go;
    logic        load;
    logic        enc_exc;
    logic [4:0]  enc_code;
    badv_sel_t   enc_badv_sel;
    slot_state_t state_q;
    slot_state_t state_d;

    exc_prio_enc u_prio_enc (
        .if_adel  (mem_exc_if_adel),
        .ri       (mem_exc_ri),
        .ov       (mem_exc_ov),
        .sys      (mem_exc_sys),
        .bp       (mem_exc_bp),
        .ld_adel  (mem_exc_ld_adel),
        .st_ades  (mem_exc_st_ades),
        .exc      (enc_exc),
        .exc_code (enc_code),
        .badv_sel (enc_badv_sel)
    );

    // WB commits in a single cycle, so the slot always drains
    assign wb_ready_go = 1'b1;
    assign wb_allowin  = !valid_r || wb_ready_go;
    assign load        = mem_to_wb_valid && wb_allowin && !ClrStpJmp;

    // Flush request is suppressed while reset is held
    assign pipe_flush  = ClrStpJmp && !rst;

    assign valid_r       = (state_q != SLOT_EMPTY);
    assign exc_in_flight = valid_r && (mem_to_wb_exception_r || mem_to_wb_eret_r);

    // Slot state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= SLOT_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Next slot state: anything not loaded this cycle leaves the slot empty
    always_comb begin
        state_d = SLOT_EMPTY;
        if (load) begin
            state_d = (enc_exc || mem_eret) ? SLOT_EXC : SLOT_NORMAL;
        end
    end

    // Commit payload: flags qualified by load, PC/data held across bubbles
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_to_wb_exception_r <= 1'b0;
            mem_to_wb_ExcCode_r   <= EXC_INT;
            mem_to_wb_bd_r        <= 1'b0;
            mem_to_wb_PC_r        <= RESET_PC;
            error_VAddr           <= 32'h0;
            mem_to_wb_eret_r      <= 1'b0;
            mem_to_wb_mtc0_op_r   <= 1'b0;
            mem_to_wb_mfc0_op_r   <= 1'b0;
            cp0_addr              <= 6'h0;
            mtc0_data             <= 32'h0;
        end else begin
            mem_to_wb_exception_r <= load && enc_exc;
            mem_to_wb_ExcCode_r   <= load ? enc_code : EXC_INT;
            mem_to_wb_bd_r        <= load && mem_bd;
            error_VAddr           <= load ? badv_mux(enc_badv_sel, mem_pc, mem_ls_addr) : 32'h0;
            // A faulting instruction never commits its CP0 operation
            mem_to_wb_eret_r      <= load && mem_eret && !enc_exc;
            mem_to_wb_mtc0_op_r   <= load && mem_mtc0 && !enc_exc;
            mem_to_wb_mfc0_op_r   <= load && mem_mfc0 && !enc_exc;
            if (load) begin
                mem_to_wb_PC_r <= mem_pc;
                cp0_addr       <= mem_cp0_addr;
                mtc0_data      <= mem_rt_data;
            end
        end
    end

endmodule
